// File: rtl/segway_pkg.sv
`default_nettype none
// ============================================================================
// Package     : segway_pkg
// Description : Shared types and constants for the rider-presence / steering
//               enable controller: FSM state encoding, default weight
//               thresholds and qualification timer widths.
// Revision    : 1.0 - initial release
// ============================================================================
package segway_pkg;

    // Controller states; 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no rider on the platform
        WAIT  = 2'd1,   // rider present, qualifying even stance
        STEER = 2'd2    // steering enabled
    } steer_state_t;

    // Default weight thresholds (sum of both load cells)
    localparam logic [11:0] MIN_RIDER_WT_DEF  = 12'h200;
    localparam logic [11:0] WT_HYSTERESIS_DEF = 12'h040;

    // Qualification timer widths: ~1.34 s at 50 MHz, or a short sim value
    localparam int TMR_W_SLOW = 26;
    localparam int TMR_W_FAST = 15;

endpackage
`default_nettype wire

// File: rtl/steer_tmr.sv
`default_nettype none
// ============================================================================
// Module      : steer_tmr
// Description : Saturating up-counter used as the stance-qualification timer.
//               Counts every clock, sticks at all ones, and is returned to
//               zero by clr (clr has priority over counting).
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               clr  - synchronous clear
//               full - counter is at all ones
// Revision    : 1.0 - initial release
// ============================================================================
module steer_tmr #(
    parameter int WIDTH = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic full
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt;

    assign full = &cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!full) begin
            cnt <= cnt + ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/steer_en_fsm.sv
`default_nettype none
// ============================================================================
// Module      : steer_en_fsm
// Description : Rider-presence and steering-enable controller. Captures each
//               left/right load-cell conversion pair and decides whether a
//               rider is present and whether they have stood evenly long
//               enough for steering to be enabled.
// Ports       : clk       - system clock (50 MHz)
//               rst       - asynchronous active-high reset
//               ld_vld    - one-cycle strobe, lft_ld/rght_ld are fresh
//               lft_ld    - left load-cell reading, unsigned 12 bit
//               rght_ld   - right load-cell reading, unsigned 12 bit
//               en_steer  - steering enabled (registered)
//               rider_off - no rider present (registered)
//               tmr_full  - qualification timer at terminal count
// Revision    : 1.0 - initial release
// ============================================================================
module steer_en_fsm
    import segway_pkg::*;
#(
    parameter int          FAST_SIM      = 0,
    parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
    parameter logic [11:0] WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off,
    output logic        tmr_full
);

    localparam int TMR_W = (FAST_SIM != 0) ? TMR_W_FAST : TMR_W_SLOW;

    // Lower threshold of the hysteresis band, widened to the sum width
    localparam logic [12:0] WT_HI = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0] WT_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

    steer_state_t state;

    logic [11:0] lft_q;
    logic [11:0] rght_q;
    logic [12:0] sum;
    logic [11:0] diff;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;
    logic        clr_tmr;

    // ------------------------------------------------------------------
    // Load capture: all decisions are made from the captured pair
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_q  <= '0;
            rght_q <= '0;
        end else if (ld_vld) begin
            lft_q  <= lft_ld;
            rght_q <= rght_ld;
        end
    end

    // ------------------------------------------------------------------
    // Weight and balance comparisons
    // ------------------------------------------------------------------
    assign sum  = {1'b0, lft_q} + {1'b0, rght_q};
    assign diff = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);

    assign sum_gt_min    = (sum > WT_HI);
    assign sum_lt_min    = (sum < WT_LO);
    // Imbalance while qualifying: difference above a quarter of the total
    assign diff_gt_1_4   = ({1'b0, diff} > (sum >> 2));
    // Imbalance while steering: nearly all weight on one foot
    assign diff_gt_15_16 = ({1'b0, diff} > (sum - (sum >> 4)));

    // ------------------------------------------------------------------
    // Timer clear: restarts qualification on mount and on any imbalance.
    // Weight loss takes precedence, so no clear when leaving for IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        clr_tmr = 1'b0;
        case (state)
            IDLE:    clr_tmr = sum_gt_min;
            WAIT:    clr_tmr = !sum_lt_min && diff_gt_1_4;
            STEER:   clr_tmr = !sum_lt_min && diff_gt_15_16;
            default: clr_tmr = 1'b0;
        endcase
    end

    steer_tmr #(
        .WIDTH (TMR_W)
    ) u_tmr (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_tmr),
        .full (tmr_full)
    );

    // ------------------------------------------------------------------
    // Controller FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (sum_gt_min) begin
                        state     <= WAIT;
                        rider_off <= 1'b0;
                    end
                end
                WAIT: begin
                    if (sum_lt_min) begin
                        state     <= IDLE;
                        rider_off <= 1'b1;
                    end else if (!diff_gt_1_4 && tmr_full) begin
                        state     <= STEER;
                        en_steer  <= 1'b1;
                    end
                end
                STEER: begin
                    if (sum_lt_min) begin
                        state     <= IDLE;
                        en_steer  <= 1'b0;
                        rider_off <= 1'b1;
                    end else if (diff_gt_15_16) begin
                        state     <= WAIT;
                        en_steer  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    en_steer  <= 1'b0;
                    rider_off <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_steer_en_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_steer_en_fsm
// Description : Self-checking bench for steer_en_fsm (short timer build).
//               A behavioural model of rider presence, steering and the
//               qualification time is advanced every clock and compared to
//               the DUT outputs; directed scenarios add explicit checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_steer_en_fsm;

    localparam int QUAL_MAX = 32767;   // timer terminal value, short build

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;
    logic        tmr_full;

    always #5 clk = ~clk;

    steer_en_fsm #(
        .FAST_SIM      (1),
        .MIN_RIDER_WT  (12'h200),
        .WT_HYSTERESIS (12'h040)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_vld    (ld_vld),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off),
        .tmr_full  (tmr_full)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    int m_l, m_r;        // captured loads
    int m_t;             // elapsed qualification time (saturating)
    bit m_present;       // rider on the platform
    bit m_steer;         // steering enabled

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_l = 0; m_r = 0; m_t = 0;
        m_present = 0; m_steer = 0;
    endtask

    // One clock edge of the reference behaviour, from the rules:
    // weight loss beats imbalance beats timer expiry.
    task automatic model_edge(input bit vld, input int l, input int r);
        int  total, delta;
        bit  restart;
        total   = m_l + m_r;
        delta   = (m_l > m_r) ? (m_l - m_r) : (m_r - m_l);
        restart = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_present) begin
            if (total > 'h200) begin
                m_present = 1;
                restart   = 1;
            end
        end else if (!m_steer) begin
            if (total < 'h1C0)              m_present = 0;
            else if (delta > total / 4)     restart   = 1;
            else if (m_t == QUAL_MAX)       m_steer   = 1;
        end else begin
            if (total < 'h1C0) begin
                m_present = 0;
                m_steer   = 0;
            end else if (delta > total - total / 16) begin
                m_steer = 0;
                restart = 1;
            end
        end
        if (restart)              m_t = 0;
        else if (m_t < QUAL_MAX)  m_t = m_t + 1;
        if (vld) begin
            m_l = l;
            m_r = r;
        end
    endtask

    // Drive one cycle, advance the model on the edge, compare just after it
    task automatic cycle(input bit vld, input logic [11:0] l, input logic [11:0] r);
        ld_vld  = vld;
        lft_ld  = l;
        rght_ld = r;
        @(posedge clk);
        model_edge(vld, int'(l), int'(r));
        cyc++;
        #1;
        check_val("en_steer",  {31'd0, en_steer},  {31'd0, m_steer});
        check_val("rider_off", {31'd0, rider_off}, {31'd0, !m_present});
        check_val("tmr_full",  {31'd0, tmr_full},  {31'd0, (m_t == QUAL_MAX)});
    endtask

    // Hold a load pair with random conversion strobes
    task automatic run(input int n, input logic [11:0] l, input logic [11:0] r);
        for (int i = 0; i < n; i++)
            cycle(($urandom_range(0, 3) == 0), l, r);
    endtask

    initial begin
        int t_cap, t_wait, t_steer;
        bit seen_wait, seen_steer;
        logic [11:0] pick [8];

        ld_vld = 0; lft_ld = '0; rght_ld = '0;
        rst = 1'b1;
        model_reset();

        // ---------------- reset ----------------
        repeat (3) cycle(0, 12'h000, 12'h000);
        rst = 1'b0;
        cycle(0, 12'h000, 12'h000);
        check_val("reset_en_steer",  {31'd0, en_steer},  32'd0);
        check_val("reset_rider_off", {31'd0, rider_off}, 32'd1);
        check_val("reset_tmr_full",  {31'd0, tmr_full},  32'd0);
        run(10, 12'h000, 12'h000);
        check_val("zero_load_idle", {31'd0, rider_off}, 32'd1);

        // ---------------- even mount ----------------
        cycle(1, 12'h180, 12'h180);
        t_cap = cyc;
        seen_wait = 0; seen_steer = 0; t_wait = 0; t_steer = 0;
        for (int i = 0; i < 33000 && !seen_steer; i++) begin
            cycle(($urandom_range(0, 3) == 0), 12'h180, 12'h180);
            if (!seen_wait && !rider_off) begin seen_wait = 1; t_wait = cyc; end
            if (!seen_steer && en_steer)  begin seen_steer = 1; t_steer = cyc; end
        end
        check_val("mount_seen_steer", {31'd0, seen_steer}, 32'd1);
        check_val("mount_wait_latency", t_wait - t_cap, 32'd1);
        check_val("qual_latency", t_steer - t_wait, 32'd32768);

        // ---------------- hysteresis band while steering ----------------
        cycle(1, 12'h0F0, 12'h0F0);     // sum 0x1E0
        run(20, 12'h0F0, 12'h0F0);
        check_val("band_stays_steer", {31'd0, en_steer}, 32'd1);

        // ---------------- async reset mid-steer ----------------
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_val("async_rst_en_steer",  {31'd0, en_steer},  32'd0);
        check_val("async_rst_rider_off", {31'd0, rider_off}, 32'd1);
        check_val("async_rst_tmr_full",  {31'd0, tmr_full},  32'd0);
        cycle(0, 12'h0F0, 12'h0F0);
        #2 rst = 1'b0;
        run(5, 12'h0F0, 12'h0F0);        // captured loads back to 0, stays idle

        // ---------------- lopsided mount ----------------
        cycle(1, 12'h300, 12'h100);
        run(1000, 12'h300, 12'h100);
        check_val("lopsided_no_steer", {31'd0, en_steer},  32'd0);
        check_val("lopsided_present",  {31'd0, rider_off}, 32'd0);
        check_val("lopsided_tmr_held", {31'd0, tmr_full},  32'd0);
        cycle(1, 12'h300, 12'h280);
        run(32780, 12'h300, 12'h280);
        check_val("rebalanced_steer", {31'd0, en_steer}, 32'd1);

        // ---------------- step off one foot ----------------
        cycle(1, 12'h400, 12'h010);
        cycle(0, 12'h400, 12'h010);
        check_val("stepoff_en_steer",  {31'd0, en_steer},  32'd0);
        check_val("stepoff_rider_off", {31'd0, rider_off}, 32'd0);
        run(10, 12'h400, 12'h010);

        // ---------------- weight below band ----------------
        cycle(1, 12'h0D8, 12'h0D8);      // sum 0x1B0
        cycle(0, 12'h0D8, 12'h0D8);
        check_val("below_band_rider_off", {31'd0, rider_off}, 32'd1);
        check_val("below_band_en_steer",  {31'd0, en_steer},  32'd0);
        cycle(1, 12'h0F0, 12'h0F0);      // inside band from idle: stays idle
        run(5, 12'h0F0, 12'h0F0);
        check_val("band_from_idle", {31'd0, rider_off}, 32'd1);

        // ---------------- randomized loads around the thresholds ----------------
        pick[0] = 12'h000; pick[1] = 12'h0D8; pick[2] = 12'h0E0; pick[3] = 12'h0F0;
        pick[4] = 12'h101; pick[5] = 12'h180; pick[6] = 12'h300; pick[7] = 12'h010;
        for (int blk = 0; blk < 60; blk++) begin
            logic [11:0] l, r;
            if ($urandom_range(0, 1) == 0) begin
                l = pick[$urandom_range(0, 7)];
                r = pick[$urandom_range(0, 7)];
            end else begin
                l = 12'($urandom_range(0, 4095));
                r = 12'($urandom_range(0, 4095));
            end
            run($urandom_range(10, 80), l, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
